// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared op encodings, FSM state type and widths for the CIM controller
// Contents: op_e (request op codes), state_e (controller FSM states), FUNC_W (CIM function width)
package cim_pkg;

    localparam int FUNC_W = 4;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_CIM   = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CAP,
        CIM,
        RSP
    } state_e;

endpackage

// File: rtl/cim_ctrl_if.sv
// rtl/cim_ctrl_if.sv - command/response handshake bundle between a requester and cim_ctrl
// Signals: req_valid/req_ready/req_op/req_addr/req_data/req_func (command),
//          rsp_valid/rsp_ready/rsp_data/rsp_err (response)
// Modports: master = requester side, slave = controller side
interface cim_ctrl_if
    import cim_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 12
);

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_data;
    logic [FUNC_W-1:0] req_func;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_data, req_func, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data, req_func, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/cim_ctrl_rsp.sv
// rtl/cim_ctrl_rsp.sv - response holding register and response handshake for cim_ctrl
// Ports: clk, rst_n (async active-low); load_i/data_i/err_i capture a new response;
//        rsp_ready_i consumer handshake; rsp_valid_o/rsp_data_o/rsp_err_o response;
//        done_o pulses on the handshake cycle
module cim_ctrl_rsp #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              err_i,
    input  logic              rsp_ready_i,
    output logic              rsp_valid_o,
    output logic [DWIDTH-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              done_o
);

    logic              rsp_valid_q;
    logic [DWIDTH-1:0] rsp_data_q;
    logic              rsp_err_q;

    // The controller only loads while no response is pending, so load and
    // handshake never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else if (load_i) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= data_i;
            rsp_err_q   <= err_i;
        end else if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign done_o      = rsp_valid_q && rsp_ready_i;

endmodule

// File: rtl/cim_ctrl.sv
// rtl/cim_ctrl.sv - command sequencer for a compute-in-memory array (write/read/CIM ops)
// Ports: clk, rst_n (async active-low); bus (cim_ctrl_if.slave command/response);
//        arr_addr/arr_din/arr_we/arr_oe/arr_cme/arr_func to the array, arr_dout from it;
//        busy (state not IDLE)
// Build option: CIM_CTRL_PERF_EN adds perf_ops, a 32-bit count of response handshakes
module cim_ctrl
    import cim_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 12,
    parameter int CIM_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cim_ctrl_if.slave         bus,
    output logic [AWIDTH-1:0] arr_addr,
    output logic [DWIDTH-1:0] arr_din,
    input  logic [DWIDTH-1:0] arr_dout,
    output logic              arr_we,
    output logic              arr_oe,
    output logic              arr_cme,
    output logic [FUNC_W-1:0] arr_func,
    output logic              busy
`ifdef CIM_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_ops
`endif
);

    generate
        if (CIM_CYCLES < 1) begin : g_bad_cim_cycles
            $error("cim_ctrl: CIM_CYCLES must be at least 1");
        end
    endgenerate

    localparam int CNT_W = (CIM_CYCLES > 1) ? $clog2(CIM_CYCLES) : 1;

    state_e            state_q;
    logic              req_ready_q;
    logic              arr_we_q;
    logic              arr_oe_q;
    logic              arr_cme_q;
    logic [AWIDTH-1:0] arr_addr_q;
    logic [DWIDTH-1:0] arr_din_q;
    logic [FUNC_W-1:0] arr_func_q;
    logic [CNT_W-1:0]  cnt_q;

    op_e               req_op_w;
    logic              accept;
    logic              rsp_load;
    logic [DWIDTH-1:0] rsp_load_data;
    logic              rsp_load_err;
    logic              rsp_done;

    assign req_op_w = op_e'(bus.req_op);
    assign accept   = (state_q == IDLE) && req_ready_q && bus.req_valid;

    // A response is captured on the last cycle of each op: WR for writes,
    // CAP (array data valid) for reads/CIM, and at acceptance for reserved ops.
    assign rsp_load      = (state_q == WR) || (state_q == CAP) ||
                           (accept && (req_op_w == OP_RSVD));
    assign rsp_load_data = (state_q == CAP) ? arr_dout : '0;
    assign rsp_load_err  = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            arr_we_q    <= 1'b0;
            arr_oe_q    <= 1'b0;
            arr_cme_q   <= 1'b0;
            arr_addr_q  <= '0;
            arr_din_q   <= '0;
            arr_func_q  <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        arr_addr_q  <= bus.req_addr;
                        arr_din_q   <= bus.req_data;
                        arr_func_q  <= bus.req_func;
                        case (req_op_w)
                            OP_WRITE: begin
                                state_q  <= WR;
                                arr_we_q <= 1'b1;
                            end
                            OP_READ: begin
                                state_q  <= RD;
                                arr_oe_q <= 1'b1;
                            end
                            OP_CIM: begin
                                state_q   <= CIM;
                                arr_cme_q <= 1'b1;
                                cnt_q     <= CNT_W'(CIM_CYCLES - 1);
                            end
                            default: begin
                                state_q <= RSP;
                            end
                        endcase
                    end else begin
                        // Also the first edge after reset release.
                        req_ready_q <= 1'b1;
                    end
                end
                WR: begin
                    arr_we_q <= 1'b0;
                    state_q  <= RSP;
                end
                RD: begin
                    arr_oe_q <= 1'b0;
                    state_q  <= CAP;
                end
                CAP: begin
                    state_q <= RSP;
                end
                CIM: begin
                    // Hand straight over to the read of the same word so the
                    // strobes stay mutually exclusive without a gap cycle.
                    if (cnt_q == '0) begin
                        arr_cme_q <= 1'b0;
                        arr_oe_q  <= 1'b1;
                        state_q   <= RD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_done) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b0;
                    arr_we_q    <= 1'b0;
                    arr_oe_q    <= 1'b0;
                    arr_cme_q   <= 1'b0;
                end
            endcase
        end
    end

    cim_ctrl_rsp #(
        .DWIDTH (DWIDTH)
    ) u_rsp (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (rsp_load),
        .data_i      (rsp_load_data),
        .err_i       (rsp_load_err),
        .rsp_ready_i (bus.rsp_ready),
        .rsp_valid_o (bus.rsp_valid),
        .rsp_data_o  (bus.rsp_data),
        .rsp_err_o   (bus.rsp_err),
        .done_o      (rsp_done)
    );

`ifdef CIM_CTRL_PERF_EN
    logic [31:0] perf_q;
    logic [31:0] perf_d;

    assign perf_d = rsp_done ? (perf_q + 32'd1) : perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_ops = perf_q;
`endif

    assign bus.req_ready = req_ready_q;
    assign arr_we        = arr_we_q;
    assign arr_oe        = arr_oe_q;
    assign arr_cme       = arr_cme_q;
    assign arr_addr      = arr_addr_q;
    assign arr_din       = arr_din_q;
    assign arr_func      = arr_func_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cim_ctrl.sv
// tb/tb_cim_ctrl.sv - self-checking bench for cim_ctrl with a behavioural CIM array
module tb_cim_ctrl;
    import cim_pkg::*;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int CC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cim_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    logic [AW-1:0] arr_addr;
    logic [DW-1:0] arr_din;
    logic [DW-1:0] arr_dout;
    logic          arr_we;
    logic          arr_oe;
    logic          arr_cme;
    logic [3:0]    arr_func;
    logic          busy;
`ifdef CIM_CTRL_PERF_EN
    logic [31:0]   perf_ops;
`endif

    cim_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .CIM_CYCLES(CC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .arr_addr (arr_addr),
        .arr_din  (arr_din),
        .arr_dout (arr_dout),
        .arr_we   (arr_we),
        .arr_oe   (arr_oe),
        .arr_cme  (arr_cme),
        .arr_func (arr_func)
`ifdef CIM_CTRL_PERF_EN
        ,
        .busy     (busy),
        .perf_ops (perf_ops)
`else
        ,
        .busy     (busy)
`endif
    );

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    func;
        int            lat;
        int            n_we;
        int            n_oe;
        int            n_cme;
        logic          err;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    // Behavioural array: CIM adds func to the word on every cme cycle.
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (arr_we)  mem[arr_addr] = arr_din;
        if (arr_cme) mem[arr_addr] = mem[arr_addr] + DW'(arr_func);
        if (arr_oe)  arr_dout <= mem[arr_addr];
    end

    exp_t          sbq[$];
    int            n_vec = 0;
    int            n_fail = 0;
    int            n_hs = 0;
    int            we_cnt, oe_cnt, cme_cnt;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;
    logic [3:0]    cur_func;
    vec_t          tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (arr_we)  we_cnt++;
            if (arr_oe)  oe_cnt++;
            if (arr_cme) cme_cnt++;
            if (arr_we || arr_oe || arr_cme) begin
                chk("strobe_excl", 64'(int'(arr_we) + int'(arr_oe) + int'(arr_cme)), 64'd1);
                chk("strobe_addr", arr_addr, cur_addr);
            end
            if (arr_we)  chk("we_din", arr_din, cur_data);
            if (arr_cme) chk("cme_func", arr_func, cur_func);
        end
    end

    function automatic vec_t mk(input logic [1:0] op, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic [3:0] func);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.func = func;
        v.n_we = 0; v.n_oe = 0; v.n_cme = 0; v.err = 1'b0;
        case (op)
            2'd0:    begin v.lat = 2;      v.n_we = 1; end
            2'd1:    begin v.lat = 3;      v.n_oe = 1; end
            2'd2:    begin v.lat = CC + 3; v.n_oe = 1; v.n_cme = CC; end
            default: begin v.lat = 1;      v.err = 1'b1; end
        endcase
        return v;
    endfunction

    function automatic void model_push(input vec_t v);
        exp_t e;
        e.data = '0;
        e.err  = 1'b0;
        case (v.op)
            2'd0: ref_mem[v.addr] = v.data;
            2'd1: e.data = ref_mem[v.addr];
            2'd2: begin
                ref_mem[v.addr] = ref_mem[v.addr] + DW'(CC * int'(v.func));
                e.data = ref_mem[v.addr];
            end
            default: e.err = 1'b1;
        endcase
        sbq.push_back(e);
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", bus.req_ready, 1'b1);
    endtask

    task automatic drive(input vec_t v, input bit push);
        cur_addr = v.addr; cur_data = v.data; cur_func = v.func;
        we_cnt = 0; oe_cnt = 0; cme_cnt = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_addr  = v.addr;
        bus.req_data  = v.data;
        bus.req_func  = v.func;
        if (push) model_push(v);
    endtask

    task automatic scramble();
        bus.req_op   = 2'($urandom);
        bus.req_addr = AW'($urandom);
        bus.req_data = $urandom;
        bus.req_func = 4'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            scramble();
        end
        chk("rsp_valid_seen", bus.rsp_valid, 1'b1);
    endtask

    task automatic check_rsp(input vec_t v, input int lat);
        exp_t e;
        e.data = 'x; e.err = 1'bx;
        if (sbq.size() > 0) e = sbq.pop_front();
        chk("latency", 64'(lat), 64'(v.lat));
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_err", bus.rsp_err, e.err);
        chk("we_cycles", 64'(we_cnt), 64'(v.n_we));
        chk("oe_cycles", 64'(oe_cnt), 64'(v.n_oe));
        chk("cme_cycles", 64'(cme_cnt), 64'(v.n_cme));
    endtask

    task automatic check_idle_after(input vec_t v);
        chk("post_rsp_valid", bus.rsp_valid, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_req_ready", bus.req_ready, 1'b1);
        chk("hold_arr_addr", arr_addr, v.addr);
        chk("hold_arr_din", arr_din, v.data);
        chk("hold_arr_func", arr_func, v.func);
    endtask

    // Full command with rsp_ready high; garbage is offered on req_* while busy.
    task automatic do_cmd(input vec_t v);
        int lat;
        wait_ready();
        drive(v, 1'b1);
        @(posedge clk);
        @(negedge clk);
        scramble();
        wait_rsp(lat);
        bus.req_valid = 1'b0;
        check_rsp(v, lat);
        @(posedge clk);
        n_hs++;
        @(negedge clk);
        check_idle_after(v);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   lat;
        logic [DW-1:0] held;

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i * 3);
            ref_mem[i] = 32'h1000_0000 + 32'(i * 3);
        end
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0;
        bus.req_data  = '0;   bus.req_func = '0; bus.rsp_ready = 1'b1;
        arr_dout = '0;
        we_cnt = 0; oe_cnt = 0; cme_cnt = 0;
        cur_addr = '0; cur_data = '0; cur_func = '0;

        tbl[0]  = mk(2'd0, 12'h005, 32'hDEADBEEF, 4'h0);
        tbl[1]  = mk(2'd1, 12'h005, 32'h1111_1111, 4'h1);
        tbl[2]  = mk(2'd2, 12'h005, 32'h0000_0000, 4'hA);
        tbl[3]  = mk(2'd3, 12'h123, 32'hCAFEF00D, 4'h3);
        tbl[4]  = mk(2'd0, 12'hFFF, 32'h1234_5678, 4'h0);
        tbl[5]  = mk(2'd1, 12'hFFF, 32'h0000_0000, 4'h0);
        tbl[6]  = mk(2'd1, 12'h000, 32'hFFFF_FFFF, 4'h7);
        tbl[7]  = mk(2'd2, 12'h000, 32'h0000_0000, 4'hF);
        tbl[8]  = mk(2'd2, 12'hFFF, 32'h0000_0000, 4'h0);
        tbl[9]  = mk(2'd1, 12'h005, 32'h0000_0000, 4'h0);
        tbl[10] = mk(2'd0, 12'h000, 32'h0000_0000, 4'h0);
        tbl[11] = mk(2'd1, 12'h000, 32'h5555_AAAA, 4'h2);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_strobes", {arr_we, arr_oe, arr_cme}, 3'b000);
        chk("rst_arr_addr", arr_addr, 12'h0);
        chk("rst_arr_din", arr_din, 32'h0);
        chk("rst_arr_func", arr_func, 4'h0);
        rst_n = 1'b1;
        #1;
        chk("req_ready_before_edge", bus.req_ready, 1'b0);
        @(negedge clk);
        chk("req_ready_first_edge", bus.req_ready, 1'b1);

        for (int i = 0; i < 12; i++) do_cmd(tbl[i]);

        // Backpressure: response held for 10 cycles while new commands are offered
        bus.rsp_ready = 1'b0;
        v = mk(2'd1, 12'h005, 32'h0, 4'h0);
        wait_ready();
        drive(v, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp(lat);
        check_rsp(v, lat);
        held = bus.rsp_data;
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 2'd0;
            bus.req_addr  = AW'($urandom);
            @(negedge clk);
            chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
            chk("bp_rsp_data", bus.rsp_data, held);
            chk("bp_req_ready", bus.req_ready, 1'b0);
            chk("bp_busy", busy, 1'b1);
        end
        bus.req_valid = 1'b0;
        chk("bp_no_write", 64'(we_cnt), 64'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        n_hs++;
        @(negedge clk);
        check_idle_after(v);

`ifdef CIM_CTRL_PERF_EN
        chk("perf_ops", perf_ops, 32'(n_hs));
`endif

        // Reset during the second CIM cycle discards the op
        v = mk(2'd2, 12'h010, 32'h55, 4'h5);
        wait_ready();
        drive(v, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_cme_1st", arr_cme, 1'b1);
        @(negedge clk);
        chk("abort_cme_2nd", arr_cme, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_cme_low", arr_cme, 1'b0);
        chk("abort_busy_low", busy, 1'b0);
        chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
        chk("abort_rsp_data", bus.rsp_data, 32'h0);
        chk("abort_arr_addr", arr_addr, 12'h0);
        chk("abort_arr_func", arr_func, 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_hs = 0;
        #1;
        chk("rerel_req_ready_pre", bus.req_ready, 1'b0);
        @(negedge clk);
        chk("rerel_req_ready", bus.req_ready, 1'b1);
        do_cmd(mk(2'd1, 12'h005, 32'h0, 4'h0));
        do_cmd(mk(2'd1, 12'hFFF, 32'h0, 4'h0));

`ifdef CIM_CTRL_PERF_EN
        chk("perf_ops_after_reset", perf_ops, 32'(n_hs));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
